// File: rtl/one_bit_pkg.sv
// one_bit_pkg: opcode map and widths for the 1-bit ALU slice
package one_bit_pkg;
  localparam int OP_W = 5;
  localparam int NUM_OPS = 20;
  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_INC    = 5'd2,
    OP_DEC    = 5'd3,
    OP_PASS_A = 5'd4,
    OP_PASS_B = 5'd5,
    OP_AND    = 5'd6,
    OP_OR     = 5'd7,
    OP_XOR    = 5'd8,
    OP_NAND   = 5'd9,
    OP_NOR    = 5'd10,
    OP_XNOR   = 5'd11,
    OP_NOT_A  = 5'd12,
    OP_NOT_B  = 5'd13,
    OP_ZERO   = 5'd14,
    OP_ONE    = 5'd15,
    OP_SHL    = 5'd16,
    OP_SHR    = 5'd17,
    OP_EQ     = 5'd18,
    OP_RSUB   = 5'd19
  } op_e;
  localparam logic [OP_W-1:0] OP_RESERVED_MIN = 5'(NUM_OPS);
endpackage

// File: rtl/one_bit_fa.sv
// one_bit_fa: combinational full adder shared by all arithmetic opcodes
module one_bit_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

// File: rtl/one_bit.sv
// one_bit: registered 1-bit ALU slice, cascaded through Cin/Cout
module one_bit
  import one_bit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a,
  input  logic            b,
  input  logic            Cin,
  input  logic [OP_W-1:0] select,
  output logic            y,
  output logic            Cout
);
  logic fa_x, fa_y, sum, carry, f, g;
  // Arithmetic opcodes differ only in operand inversion or a constant B
  always_comb begin
    fa_x = (select == OP_RSUB) ? ~a : a;
    fa_y = (select == OP_SUB) ? ~b : (select == OP_INC) ? 1'b0 : (select == OP_DEC) ? 1'b1 : b;
  end
  one_bit_fa u_fa (.x(fa_x), .y(fa_y), .ci(Cin), .s(sum), .co(carry));
  always_comb begin
    f = 1'b0;
    g = 1'b0;
    case (select)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_RSUB: begin
        f = sum;
        g = carry;
      end
      OP_PASS_A: f = a;
      OP_PASS_B: f = b;
      OP_AND:    f = a & b;
      OP_OR:     f = a | b;
      OP_XOR:    f = a ^ b;
      OP_NAND:   f = ~(a & b);
      OP_NOR:    f = ~(a | b);
      OP_XNOR:   f = ~(a ^ b);
      OP_NOT_A:  f = ~a;
      OP_NOT_B:  f = ~b;
      OP_ZERO:   f = 1'b0;
      OP_ONE:    f = 1'b1;
      OP_SHL, OP_SHR: begin
        f = Cin;
        g = a;
      end
      OP_EQ: begin
        f = Cin & ~(a ^ b);
        g = Cin & ~(a ^ b);
      end
      default: begin
        f = 1'b0;
        g = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= 1'b0;
      Cout <= 1'b0;
    end else begin
      y <= f;
      Cout <= g;
    end
  end
endmodule

// File: tb/tb_one_bit.sv
// tb_one_bit: directed scoreboard bench for the 1-bit ALU slice
module tb_one_bit;
  logic clk = 1'b0;
  logic rst_n, a, b, cin;
  logic [4:0] sel;
  logic y, cout;
  int checks = 0;
  int errors = 0;
  logic [1:0] sb_q[$];
  string tag_q[$];

  one_bit dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .Cin(cin), .select(sel), .y(y), .Cout(cout));

  always #5 clk = ~clk;

  // Reference model: returns {y, Cout} via 2-bit arithmetic sums
  function automatic logic [1:0] model(input logic ma, input logic mb, input logic mc, input logic [4:0] ms);
    logic [1:0] s;
    logic e;
    s = 2'b00;
    case (ms)
      5'd0:  s = 2'(ma) + 2'(mb) + 2'(mc);
      5'd1:  s = 2'(ma) + 2'(!mb) + 2'(mc);
      5'd2:  s = 2'(ma) + 2'(mc);
      5'd3:  s = 2'(ma) + 2'd1 + 2'(mc);
      5'd19: s = 2'(!ma) + 2'(mb) + 2'(mc);
      5'd4:  s = {1'b0, ma};
      5'd5:  s = {1'b0, mb};
      5'd6:  s = {1'b0, ma && mb};
      5'd7:  s = {1'b0, ma || mb};
      5'd8:  s = {1'b0, ma != mb};
      5'd9:  s = {1'b0, !(ma && mb)};
      5'd10: s = {1'b0, !(ma || mb)};
      5'd11: s = {1'b0, ma == mb};
      5'd12: s = {1'b0, !ma};
      5'd13: s = {1'b0, !mb};
      5'd15: s = 2'b01;
      5'd16, 5'd17: s = {ma, mc};
      5'd18: begin
        e = mc && (ma == mb);
        s = {e, e};
      end
      default: s = 2'b00;
    endcase
    return {s[0], s[1]};
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed y,Cout=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic va, input logic vb, input logic vc, input logic [4:0] vs, input string tag);
    @(negedge clk);
    a = va;
    b = vb;
    cin = vc;
    sel = vs;
    sb_q.push_back(model(va, vb, vc, vs));
    tag_q.push_back(tag);
  endtask

  task automatic collect();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else
      check(tag_q.pop_front(), {y, cout}, sb_q.pop_front());
  endtask

  task automatic step(input logic va, input logic vb, input logic vc, input logic [4:0] vs, input string tag);
    drive(va, vb, vc, vs, tag);
    collect();
  endtask

  initial begin
    rst_n = 1'b0;
    a = 1'b1;
    b = 1'b1;
    cin = 1'b0;
    sel = 5'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_hold%0d", i), {y, cout}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_released_pre_edge", {y, cout}, 2'b00);
    sb_q.push_back(2'b01);
    tag_q.push_back("reset_first_edge");
    collect();
    for (int op = 0; op < 20; op++) begin
      step(1'b1, 1'b1, 1'b0, 5'(op), $sformatf("sweep_op%0d", op));
      step(1'b1, 1'b1, 1'b0, 5'(op), $sformatf("sweep_op%0d_hold", op));
    end
    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      step(v[2], v[1], v[0], 5'd0, $sformatf("add_abc%0b", v));
    end
    step(1'b1, 1'b1, 1'b1, 5'd18, "eq_match");
    step(1'b1, 1'b0, 1'b1, 5'd18, "eq_mismatch");
    for (int op = 20; op < 32; op++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 5'(op), $sformatf("reserved_op%0d", op));
    for (int k = 0; k < 10; k++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(19)), $sformatf("random%0d", k));
    step(1'b0, 1'b0, 1'b0, 5'd15, "latency_one");
    @(negedge clk);
    sel = 5'd14;
    #1;
    check("latency_pre_edge", {y, cout}, 2'b10);
    sb_q.push_back(2'b00);
    tag_q.push_back("latency_zero");
    collect();
    step(1'b0, 1'b0, 1'b0, 5'd15, "async_setup");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", {y, cout}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 5'd0, "after_async");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
